// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port synchronous VRAM between display fetch (absolute priority)
// and the CPU req/ack bus. Optional macro VRAM_ARB_BLANK_WRITE_EN restricts CPU writes to vblank.
module vram_arbiter #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_data,
  output logic          disp_valid,
  input  logic          vblank,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    TAG_NONE,
    TAG_DISP,
    TAG_CPU_RD,
    TAG_CPU_WR
  } tag_e;

  tag_e          slot_d, tag1_q, tag2_q;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] disp_data_q, disp_data_d;
  logic          disp_valid_q, disp_valid_d;
  logic          cpu_ack_q, cpu_ack_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic          cpu_busy_q, cpu_busy_d;
  logic          wr_ok;

`ifdef VRAM_ARB_BLANK_WRITE_EN
  // Writes wait for vertical blanking; reads are never gated.
  assign wr_ok = ~cpu_we | vblank;
`else
  logic unused_vblank;
  assign wr_ok         = 1'b1;
  assign unused_vblank = vblank;
`endif

  // State register: slot issue stage plus two-stage tag pipe.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      tag1_q       <= TAG_NONE;
      tag2_q       <= TAG_NONE;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      cpu_ack_q    <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_busy_q   <= 1'b0;
    end else begin
      tag1_q       <= slot_d;
      tag2_q       <= tag1_q;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      cpu_ack_q    <= cpu_ack_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_busy_q   <= cpu_busy_d;
    end
  end

  // Next-state: grant, slot issue and completion of tagged slots.
  always_comb begin
    slot_d = TAG_NONE;
    if (disp_req) begin
      slot_d = TAG_DISP;
    end else if (cpu_req && !cpu_busy_q && !cpu_ack_q && wr_ok) begin
      slot_d = cpu_we ? TAG_CPU_WR : TAG_CPU_RD;
    end

    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    unique case (slot_d)
      TAG_DISP:   mem_addr_d = disp_addr;
      TAG_CPU_RD: mem_addr_d = cpu_addr;
      TAG_CPU_WR: begin
        mem_addr_d  = cpu_addr;
        mem_we_d    = 1'b1;
        mem_wdata_d = cpu_wdata;
      end
      default: ;
    endcase

    // Stage 1 completes writes; stage 2 sees the RAM read data.
    disp_valid_d = (tag2_q == TAG_DISP);
    disp_data_d  = (tag2_q == TAG_DISP) ? mem_rdata : disp_data_q;
    cpu_rdata_d  = (tag2_q == TAG_CPU_RD) ? mem_rdata : cpu_rdata_q;
    cpu_ack_d    = (tag1_q == TAG_CPU_WR) || (tag2_q == TAG_CPU_RD);

    cpu_busy_d = cpu_busy_q;
    if (slot_d == TAG_CPU_RD || slot_d == TAG_CPU_WR) begin
      cpu_busy_d = 1'b1;
    end else if (cpu_ack_d) begin
      cpu_busy_d = 1'b0;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    mem_addr   = mem_addr_q;
    mem_we     = mem_we_q;
    mem_wdata  = mem_wdata_q;
    disp_data  = disp_data_q;
    disp_valid = disp_valid_q;
    cpu_ack    = cpu_ack_q;
    cpu_rdata  = cpu_rdata_q;
  end

endmodule
